// File: rtl/ps2_device.sv
`timescale 1ns/1ps
// ps2_device -- PS/2 device-side port (keyboard/mouse endpoint emulation).
//
// Generates the PS/2 bus clock, transmits bytes to a PS/2 host and receives
// host command bytes, acknowledging each. Lines are open-drain: a *DR0 output
// of 1 pulls the line low, 0 releases it.
//
// Optional feature macro: PS2DEV_RESEND_EN
//   defined   : a frame aborted by host inhibit stays pending and is resent
//               once the bus has been idle again.
//   undefined : an aborted byte is discarded (tx_ready_o returns to 1).
//
// Ports:
//   clk6x        48 MHz system clock
//   resetn       asynchronous active-low reset
//   ck1us        1 us strobe, one clk6x cycle wide
//   PS2_CLK      bus CLK line state (asynchronous)
//   PS2_DATA     bus DATA line state (asynchronous)
//   PS2_CLKDR0   1 = pull CLK low
//   PS2_DATADR0  1 = pull DATA low
//   tx_data_i    byte to send to the host
//   tx_v_i       load tx_data_i when tx_ready_o=1
//   tx_ready_o   transmit holding register empty
//   tx_done_o    pulse: frame fully clocked out
//   tx_abort_o   pulse: host inhibited the frame
//   rx_data_o    last received host byte
//   rx_v_o       pulse: good byte received
//   rx_err_o     pulse: parity or stop error
module ps2_device #(
  parameter int HALF_PERIOD  = 40,
  parameter int DATA_AT      = 20,
  parameter int INH_CHECK_AT = 5,
  parameter int IDLE_MIN     = 50
) (
  input  logic       clk6x,
  input  logic       resetn,
  input  logic       ck1us,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       PS2_CLKDR0,
  output logic       PS2_DATADR0,
  input  logic [7:0] tx_data_i,
  input  logic       tx_v_i,
  output logic       tx_ready_o,
  output logic       tx_done_o,
  output logic       tx_abort_o,
  output logic [7:0] rx_data_o,
  output logic       rx_v_o,
  output logic       rx_err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_HIGH, S_TX_LOW, S_ABORT, S_RX_HIGH0, S_RX_LOW, S_RX_HIGH
  } state_t;

  // Phase events fire on the strobe that brings the phase timer to N us.
  localparam logic [7:0] PH_INH   = 8'(INH_CHECK_AT - 1);
  localparam logic [7:0] PH_DATA  = 8'(DATA_AT - 1);
  localparam logic [7:0] PH_HALF  = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] IDLE_THR = 8'(IDLE_MIN);

  logic [1:0]  clk_sync, data_sync;
  logic        clk_s, data_s;
  state_t      state, state_nx;
  logic [7:0]  phase_cnt, idle_cnt;
  logic [3:0]  bit_cnt, bit_cnt_nx;     // n during TX, k during RX
  logic [7:0]  tx_buf;
  logic        tx_pend, tx_pend_clr;
  logic [10:0] tx_frame;
  logic [7:0]  rx_sh, rx_sh_nx, rx_data_nx;
  logic        rx_par, rx_par_nx, rx_stop, rx_stop_nx;
  logic        clkdr_nx, datadr_nx;
  logic        tx_done_nx, tx_abort_nx, rx_v_nx, rx_err_nx;
  logic        ev_inh, ev_data, ev_half;

  // NOTE: the bus lines are asynchronous; only the second flop of each
  // synchronizer may feed logic.
  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  assign ev_inh  = ck1us && (phase_cnt == PH_INH);
  assign ev_data = ck1us && (phase_cnt == PH_DATA);
  assign ev_half = ck1us && (phase_cnt == PH_HALF);

  // Start, d0..d7, odd parity, stop -- indexed by the bit counter.
  assign tx_frame   = {1'b1, ~^tx_buf, tx_buf, 1'b0};
  assign tx_ready_o = ~tx_pend;

  // NOTE: every signal assigned here gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nx    = state;
    bit_cnt_nx  = bit_cnt;
    clkdr_nx    = PS2_CLKDR0;
    datadr_nx   = PS2_DATADR0;
    rx_sh_nx    = rx_sh;
    rx_par_nx   = rx_par;
    rx_stop_nx  = rx_stop;
    rx_data_nx  = rx_data_o;
    tx_done_nx  = 1'b0;
    tx_abort_nx = 1'b0;
    rx_v_nx     = 1'b0;
    rx_err_nx   = 1'b0;
    tx_pend_clr = 1'b0;

    unique case (state)
      S_IDLE: begin
        clkdr_nx  = 1'b0;
        datadr_nx = 1'b0;
        // Host request-to-send wins over a pending transmit.
        if (clk_s && !data_s) begin
          state_nx = S_RX_HIGH0;
        end else if (tx_pend && (idle_cnt >= IDLE_THR)) begin
          state_nx   = S_TX_HIGH;
          bit_cnt_nx = 4'd0;
        end
      end

      S_TX_HIGH: begin
        if (ev_inh && !clk_s) begin
          datadr_nx = 1'b0;
          state_nx  = S_ABORT;
        end else if (ev_data) begin
          datadr_nx = ~tx_frame[bit_cnt];
        end else if (ev_half) begin
          clkdr_nx = 1'b1;
          state_nx = S_TX_LOW;
        end
      end

      S_TX_LOW: begin
        if (ev_half) begin
          clkdr_nx = 1'b0;
          if (bit_cnt == 4'd10) begin
            datadr_nx   = 1'b0;
            tx_done_nx  = 1'b1;
            tx_pend_clr = 1'b1;
            state_nx    = S_IDLE;
          end else begin
            bit_cnt_nx = bit_cnt + 4'd1;
            state_nx   = S_TX_HIGH;
          end
        end
      end

      S_ABORT: begin
        clkdr_nx    = 1'b0;
        datadr_nx   = 1'b0;
        tx_abort_nx = 1'b1;
`ifdef PS2DEV_RESEND_EN
        tx_pend_clr = 1'b0;           // byte stays pending for a resend
`else
        tx_pend_clr = 1'b1;
`endif
        state_nx    = S_IDLE;
      end

      S_RX_HIGH0: begin
        if (ev_half) begin
          clkdr_nx   = 1'b1;
          bit_cnt_nx = 4'd1;
          state_nx   = S_RX_LOW;
        end
      end

      S_RX_LOW: begin
        if (ev_half) begin
          clkdr_nx = 1'b0;
          if (bit_cnt == 4'd11) begin
            // Clock 11 ends: drop the ACK together with CLK.
            datadr_nx  = 1'b0;
            rx_data_nx = rx_sh;
            if ((^{rx_sh, rx_par}) && rx_stop) rx_v_nx = 1'b1;
            else                               rx_err_nx = 1'b1;
            state_nx   = S_IDLE;
          end else begin
            state_nx = S_RX_HIGH;
          end
        end
      end

      S_RX_HIGH: begin
        if (ev_inh) begin
          if (!clk_s) begin
            // Host cancel: silent return to idle.
            clkdr_nx  = 1'b0;
            datadr_nx = 1'b0;
            state_nx  = S_IDLE;
          end else if (bit_cnt <= 4'd8) begin
            rx_sh_nx = {data_s, rx_sh[7:1]};
          end else if (bit_cnt == 4'd9) begin
            rx_par_nx = data_s;
          end else begin
            rx_stop_nx = data_s;
          end
        end else if (ev_data) begin
          if (bit_cnt == 4'd10 && rx_stop) datadr_nx = 1'b1;   // ACK
        end else if (ev_half) begin
          clkdr_nx   = 1'b1;
          bit_cnt_nx = bit_cnt + 4'd1;
          state_nx   = S_RX_LOW;
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the small data registers (tx_buf, rx_sh) are reset too; there is
  // no RAM here, so a known value costs nothing and simplifies debug.
  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      clk_sync    <= 2'b11;
      data_sync   <= 2'b11;
      state       <= S_IDLE;
      phase_cnt   <= '0;
      idle_cnt    <= '0;
      bit_cnt     <= '0;
      tx_buf      <= '0;
      tx_pend     <= 1'b0;
      rx_sh       <= '0;
      rx_par      <= 1'b0;
      rx_stop     <= 1'b0;
      rx_data_o   <= '0;
      PS2_CLKDR0  <= 1'b0;
      PS2_DATADR0 <= 1'b0;
      tx_done_o   <= 1'b0;
      tx_abort_o  <= 1'b0;
      rx_v_o      <= 1'b0;
      rx_err_o    <= 1'b0;
    end else begin
      clk_sync    <= {clk_sync[0], PS2_CLK};
      data_sync   <= {data_sync[0], PS2_DATA};
      state       <= state_nx;
      bit_cnt     <= bit_cnt_nx;
      rx_sh       <= rx_sh_nx;
      rx_par      <= rx_par_nx;
      rx_stop     <= rx_stop_nx;
      rx_data_o   <= rx_data_nx;
      PS2_CLKDR0  <= clkdr_nx;
      PS2_DATADR0 <= datadr_nx;
      tx_done_o   <= tx_done_nx;
      tx_abort_o  <= tx_abort_nx;
      rx_v_o      <= rx_v_nx;
      rx_err_o    <= rx_err_nx;

      // Phase timer restarts on every state entry.
      if (state_nx != state) phase_cnt <= '0;
      else                   phase_cnt <= phase_cnt + 8'(ck1us);

      if (state_nx == S_IDLE && state != S_IDLE)  idle_cnt <= '0;
      else if (!(clk_s && data_s))                idle_cnt <= '0;
      else if (ck1us && idle_cnt != 8'hFF)        idle_cnt <= idle_cnt + 8'd1;

      // Load and clear never coincide: clear only happens while pending.
      if (tx_v_i && !tx_pend) begin
        tx_buf  <= tx_data_i;
        tx_pend <= 1'b1;
      end else if (tx_pend_clr) begin
        tx_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_device.sv
`timescale 1ns/1ps
// tb_ps2_device -- self-checking bench for ps2_device.
// Models an open-drain bus with a PS/2 host on the other side. Expected
// output pulses are queued when stimulus is driven and popped by a monitor
// when the DUT pulses. One "us" of bus time is US_CYC clk6x cycles here.
module tb_ps2_device;

  localparam int US_CYC = 6;
  localparam int HALF   = 40;

  logic       clk6x = 1'b0;
  logic       resetn = 1'b0;
  logic       ck1us = 1'b0;
  logic       host_clk_low = 1'b0;
  logic       host_data_low = 1'b0;
  logic       ps2_clk, ps2_data;
  logic       PS2_CLKDR0, PS2_DATADR0;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_v_i = 1'b0;
  logic       tx_ready_o, tx_done_o, tx_abort_o, rx_v_o, rx_err_o;
  logic [7:0] rx_data_o;

  int n_tests = 0;
  int n_fail  = 0;
  int us_now  = 0;
  int last_pulse_us = 0;

  typedef enum logic [1:0] {EV_RX_OK, EV_RX_ERR, EV_TX_DONE, EV_TX_ABORT} ev_kind_t;
  typedef struct packed { ev_kind_t kind; logic [7:0] data; } ev_t;
  ev_t sb[$];

  assign ps2_clk  = ~(PS2_CLKDR0 | host_clk_low);
  assign ps2_data = ~(PS2_DATADR0 | host_data_low);

  ps2_device dut (
    .clk6x       (clk6x),
    .resetn      (resetn),
    .ck1us       (ck1us),
    .PS2_CLK     (ps2_clk),
    .PS2_DATA    (ps2_data),
    .PS2_CLKDR0  (PS2_CLKDR0),
    .PS2_DATADR0 (PS2_DATADR0),
    .tx_data_i   (tx_data_i),
    .tx_v_i      (tx_v_i),
    .tx_ready_o  (tx_ready_o),
    .tx_done_o   (tx_done_o),
    .tx_abort_o  (tx_abort_o),
    .rx_data_o   (rx_data_o),
    .rx_v_o      (rx_v_o),
    .rx_err_o    (rx_err_o)
  );

  always #10 clk6x = ~clk6x;

  initial begin
    forever begin
      repeat (US_CYC - 1) @(negedge clk6x);
      ck1us = 1'b1;
      @(negedge clk6x);
      ck1us = 1'b0;
      us_now++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d us)", tag, got, exp, us_now);
    end
  endtask

  function automatic logic par_of(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, par_of(d), d, 1'b0};
  endfunction

  // Pulse monitor: every DUT pulse must match the head of the scoreboard.
  always @(negedge clk6x) begin
    ev_t      e;
    ev_kind_t k;
    logic [3:0] pulses;
    pulses = {rx_v_o, rx_err_o, tx_done_o, tx_abort_o};
    if (resetn && pulses != 4'b0000) begin
      last_pulse_us = us_now;
      check("pulse_onehot", 32'($countones(pulses)), 32'd1);
      k = rx_v_o ? EV_RX_OK : rx_err_o ? EV_RX_ERR : tx_done_o ? EV_TX_DONE : EV_TX_ABORT;
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(pulses), 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", 32'(k), 32'(e.kind));
        if (k == EV_RX_OK || k == EV_RX_ERR) check("rx_data", 32'(rx_data_o), 32'(e.data));
`ifdef PS2DEV_RESEND_EN
        if (k == EV_TX_ABORT) check("abort_ready", 32'(tx_ready_o), 32'd0);
`else
        if (k == EV_TX_ABORT) check("abort_ready", 32'(tx_ready_o), 32'd1);
`endif
      end
    end
  end

  task automatic push_ev(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_us(input int us);
    repeat (us * US_CYC) @(negedge clk6x);
  endtask

  task automatic wait_fall(input int budget_us, output bit seen);
    logic prev;
    seen = 1'b0;
    prev = ps2_clk;
    for (int i = 0; i < budget_us * US_CYC; i++) begin
      @(negedge clk6x);
      if (prev && !ps2_clk) begin
        seen = 1'b1;
        break;
      end
      prev = ps2_clk;
    end
  endtask

  // Host receive: samples DATA at each falling CLK edge, 11 bits.
  task automatic host_get_frame(output logic [10:0] fr, output int t_first, output bit ok);
    bit seen;
    fr = '0;
    t_first = 0;
    ok = 1'b1;
    for (int i = 0; i < 11; i++) begin
      wait_fall(400, seen);
      if (!seen) begin
        ok = 1'b0;
        break;
      end
      if (i == 0) t_first = us_now;
      fr[i] = ps2_data;
    end
  endtask

  // Host send: RTS (DATA low), then a new bit on each device falling edge.
  task automatic host_send(input logic [7:0] d, input logic par, output bit ack, output bit ok);
    bit seen;
    ack = 1'b0;
    ok = 1'b1;
    host_data_low = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      wait_fall(200, seen);
      if (!seen) begin
        ok = 1'b0;
        break;
      end
      if (c <= 8)       host_data_low = ~d[c-1];
      else if (c == 9)  host_data_low = ~par;
      else if (c == 10) host_data_low = 1'b0;
      else begin
        wait_us(2);
        ack = ~ps2_data;
      end
    end
    host_data_low = 1'b0;
  endtask

  task automatic send_tx_byte(input logic [7:0] d);
    @(negedge clk6x);
    check("ready_before_load", 32'(tx_ready_o), 32'd1);
    tx_data_i = d;
    tx_v_i = 1'b1;
    @(negedge clk6x);
    tx_v_i = 1'b0;
    check("ready_after_load", 32'(tx_ready_o), 32'd0);
  endtask

  task automatic drain(input string tag, input int budget_us);
    for (int i = 0; i < budget_us * US_CYC && sb.size() != 0; i++) @(negedge clk6x);
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_800_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] fr;
    logic [10:0] req_1c;
    int          t_first, diff;
    bit          ok, ack, seen;

    req_1c = 11'b100_0011_1000;   // stop,par,d7..d0,start for 0x1C

    // ---- reset state ----
    repeat (5) @(negedge clk6x);
    check("rst_clkdr", 32'(PS2_CLKDR0), 32'd0);
    check("rst_datadr", 32'(PS2_DATADR0), 32'd0);
    check("rst_ready", 32'(tx_ready_o), 32'd1);
    check("rst_pulses", 32'({rx_v_o, rx_err_o, tx_done_o, tx_abort_o}), 32'd0);
    check("rst_rx_data", 32'(rx_data_o), 32'd0);
    resetn = 1'b1;
    wait_us(60);

    // ---- TX 0x1C on an idle bus ----
    push_ev(EV_TX_DONE, 8'h00);
    send_tx_byte(8'h1C);
    host_get_frame(fr, t_first, ok);
    check("tx1_frame_seen", 32'(ok), 32'd1);
    check("tx1_frame_1c", 32'(fr), 32'(req_1c));
    drain("tx1_drain", 200);
    // Frame start lies one high phase before the first falling edge.
    diff = last_pulse_us - t_first + HALF;
    check("tx1_frame_880us", 32'(diff >= 878 && diff <= 882), 32'd1);
    check("tx1_ready", 32'(tx_ready_o), 32'd1);
    wait_us(20);

    // ---- host sends 0x55 ----
    push_ev(EV_RX_OK, 8'h55);
    host_send(8'h55, par_of(8'h55), ack, ok);
    check("rx55_done", 32'(ok), 32'd1);
    check("rx55_ack", 32'(ack), 32'd1);
    drain("rx55_drain", 100);
    check("rx55_data", 32'(rx_data_o), 32'h55);
    wait_us(20);

    // ---- host sends 0xFF with bad parity ----
    push_ev(EV_RX_ERR, 8'hFF);
    host_send(8'hFF, ~par_of(8'hFF), ack, ok);
    check("rxff_done", 32'(ok), 32'd1);
    check("rxff_ack", 32'(ack), 32'd1);
    drain("rxff_drain", 100);
    wait_us(60);

    // ---- host inhibit before clock 5 ----
    push_ev(EV_TX_ABORT, 8'h00);
`ifdef PS2DEV_RESEND_EN
    push_ev(EV_TX_DONE, 8'h00);
`endif
    send_tx_byte(8'h1C);
    for (int i = 0; i < 4; i++) begin
      wait_fall(400, seen);
      check("abort_fall_seen", 32'(seen), 32'd1);
    end
    for (int i = 0; i < 100 * US_CYC && !ps2_clk; i++) @(negedge clk6x);
    check("abort_rise_seen", 32'(ps2_clk), 32'd1);
    wait_us(2);
    host_clk_low = 1'b1;
    wait_us(100);
    host_clk_low = 1'b0;
`ifdef PS2DEV_RESEND_EN
    host_get_frame(fr, t_first, ok);
    check("resend_seen", 32'(ok), 32'd1);
    check("resend_frame", 32'(fr), 32'(req_1c));
    drain("resend_drain", 200);
`else
    wait_fall(300, seen);
    check("no_retransmit", 32'(seen), 32'd0);
    check("abort_ready_idle", 32'(tx_ready_o), 32'd1);
    drain("abort_drain", 10);
`endif
    wait_us(60);

    // ---- TX load in the cycle the RTS reaches the FSM ----
    // RTS passes the 2-flop synchronizer one edge after tx_v_i is sampled,
    // so the pending byte and RTS are evaluated in the same idle cycle.
    push_ev(EV_RX_OK, 8'hA3);
    push_ev(EV_TX_DONE, 8'h00);
    @(negedge clk6x);
    host_data_low = 1'b1;
    @(negedge clk6x);
    tx_data_i = 8'h3A;
    tx_v_i = 1'b1;
    @(negedge clk6x);
    tx_v_i = 1'b0;
    host_send(8'hA3, par_of(8'hA3), ack, ok);
    check("race_rx_done", 32'(ok), 32'd1);
    check("race_rx_ack", 32'(ack), 32'd1);
    host_get_frame(fr, t_first, ok);
    check("race_tx_seen", 32'(ok), 32'd1);
    check("race_tx_frame", 32'(fr), 32'(frame_of(8'h3A)));
    // last_pulse_us still holds the rx_v_o time until the TX done pulse.
    check("race_tx_gap_ge50", 32'((t_first - last_pulse_us) >= 50), 32'd1);
    drain("race_drain", 1000);
    wait_us(60);

    // ---- reset during bit 6 (clock 7 low phase) ----
    send_tx_byte(8'h1C);
    for (int i = 0; i < 7; i++) wait_fall(400, seen);
    check("rst_mid_fall_seen", 32'(seen), 32'd1);
    wait_us(5);
    check("mid_clkdr", 32'(PS2_CLKDR0), 32'd1);
    check("mid_datadr_bit6", 32'(PS2_DATADR0), 32'd1);
    #3;
    resetn = 1'b0;
    #1;
    check("async_clkdr", 32'(PS2_CLKDR0), 32'd0);
    check("async_datadr", 32'(PS2_DATADR0), 32'd0);
    check("async_ready", 32'(tx_ready_o), 32'd1);
    check("async_pulses", 32'({rx_v_o, rx_err_o, tx_done_o, tx_abort_o}), 32'd0);
    @(negedge clk6x);
    resetn = 1'b1;
    wait_fall(300, seen);
    check("post_rst_quiet", 32'(seen), 32'd0);
    drain("post_rst_drain", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
